// File: rtl/mem_port_ctrl_pkg.sv
// Shared types and helpers for the port-2 memory initiator.
package mem_port_ctrl_pkg;

  localparam int unsigned DataW = 16;

  // Controller states; encodings are fixed so waveforms decode consistently.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Access size of a request.
  typedef enum logic {
    SizeWord = 1'b0,
    SizeByte = 1'b1
  } size_e;

  // Sign-extend a loaded byte to a full data word.
  function automatic logic [DataW-1:0] sext_byte(input logic [7:0] b);
    return {{(DataW - 8){b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_port_ctrl_byte_lane_align.sv
// Byte-lane steering: store lane enables and data replication, load byte
// selection with sign extension. Purely combinational.
module mem_port_ctrl_byte_lane_align
  import mem_port_ctrl_pkg::*;
(
  input  logic             addr_lsb_i,
  input  logic             byte_i,
  input  logic             we_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [DataW-1:0] rdata_i,
  output logic             we_low_o,
  output logic             we_hi_o,
  output logic [DataW-1:0] wdata_o,
  output logic [DataW-1:0] rdata_o
);

  size_e size;
  assign size = byte_i ? SizeByte : SizeWord;

  // Lane enables and data steering for the decoded access size.
  always_comb begin
    we_low_o = 1'b0;
    we_hi_o  = 1'b0;
    wdata_o  = wdata_i;
    rdata_o  = rdata_i;
    unique case (size)
      SizeByte: begin
        // Replicate so the byte lands correctly whichever lane is enabled.
        wdata_o  = {wdata_i[7:0], wdata_i[7:0]};
        rdata_o  = sext_byte(addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0]);
        we_low_o = we_i & ~addr_lsb_i;
        we_hi_o  = we_i & addr_lsb_i;
      end
      default: begin
        we_low_o = we_i;
        we_hi_o  = we_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Port-2 memory initiator: accepts one load/store from the MEM stage, runs a
// single memory transaction and returns a one-cycle response pulse.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_byte,
  input  logic [DataW-1:0] req_addr,
  input  logic [DataW-1:0] req_wdata,
  output logic             resp_valid,
  output logic [DataW-1:0] resp_data,
  output logic             resp_err,
  output logic             mem_en,
  output logic             mem_we_low,
  output logic             mem_we_hi,
  output logic [DataW-1:0] mem_addr,
  output logic [DataW-1:0] mem_wdata,
  input  logic [DataW-1:0] mem_rdata,
  input  logic             mem_ready
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DataW-1:0] addr_q;
  logic             we_q;
  logic             byte_q;

  logic             req_ready_q;
  logic             mem_en_q;
  logic             mem_we_low_q;
  logic             mem_we_hi_q;
  logic [DataW-1:0] mem_wdata_q;
  logic             resp_valid_q;
  logic [DataW-1:0] resp_data_q;
  logic             resp_err_q;

  logic             lane_addr_lsb;
  logic             lane_byte;
  logic             lane_we_low;
  logic             lane_we_hi;
  logic [DataW-1:0] lane_wdata;
  logic [DataW-1:0] lane_rdata;

  // In IDLE the aligner looks at the incoming request so store lanes can be
  // registered at accept; afterwards it decodes the held request for loads.
  assign lane_addr_lsb = (state_q == StIdle) ? req_addr[0] : addr_q[0];
  assign lane_byte     = (state_q == StIdle) ? req_byte : byte_q;

  mem_port_ctrl_byte_lane_align u_align (
    .addr_lsb_i (lane_addr_lsb),
    .byte_i     (lane_byte),
    .we_i       (req_we),
    .wdata_i    (req_wdata),
    .rdata_i    (mem_rdata),
    .we_low_o   (lane_we_low),
    .we_hi_o    (lane_we_hi),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  // Transaction FSM with registered request, counter and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_low_q <= 1'b0;
      mem_we_hi_q  <= 1'b0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      // Write enables and the response are single-cycle pulses.
      mem_we_low_q <= 1'b0;
      mem_we_hi_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            we_q        <= req_we;
            byte_q      <= req_byte;
            req_ready_q <= 1'b0;
            if (!req_byte && req_addr[0]) begin
              // Unaligned word: answer with an error, never touch memory.
              state_q      <= StDone;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q      <= StIssue;
              mem_en_q     <= 1'b1;
              mem_we_low_q <= lane_we_low;
              mem_we_hi_q  <= lane_we_hi;
              mem_wdata_q  <= lane_wdata;
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
          cnt_q   <= '0;
        end
        StWait: begin
          if (mem_ready) begin
            state_q      <= StDone;
            mem_en_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= we_q ? '0 : lane_rdata;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q      <= StDone;
            mem_en_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
          mem_en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_en     = mem_en_q;
  assign mem_we_low = mem_we_low_q;
  assign mem_we_hi  = mem_we_hi_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed vector table, corner-case
// sequences and randomized transactions against a byte-addressed memory model.
module tb_mem_port_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we_low;
  logic        mem_we_hi;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_port_ctrl #(
    .TIMEOUT (16),
    .CNT_W   (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we_low (mem_we_low),
    .mem_we_hi  (mem_we_hi),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the port: word array aliased on address bits [7:1].
  bit [15:0] mem [128];
  bit        mem_stall = 1'b0;
  int        mem_delay = 0;
  int        lat_cnt = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we_low) mem[mem_addr[7:1]][7:0] <= mem_wdata[7:0];
      if (mem_we_hi)  mem[mem_addr[7:1]][15:8] <= mem_wdata[15:8];
      mem_rdata <= mem[mem_addr[7:1]];
      mem_ready <= !mem_stall && (lat_cnt == mem_delay);
      lat_cnt   <= lat_cnt + 1;
    end else begin
      mem_ready <= 1'b0;
      lat_cnt   <= 0;
    end
  end

  // Reference: flat byte-addressed memory, same 256-byte aliasing.
  bit [7:0] ref_bytes [256];

  function automatic logic [15:0] ref_load(input logic byt, input logic [15:0] a);
    logic [7:0] lo;
    logic [7:0] hi;
    if (byt) return 16'($signed(ref_bytes[a[7:0]]));
    lo = ref_bytes[{a[7:1], 1'b0}];
    hi = ref_bytes[{a[7:1], 1'b1}];
    return {hi, lo};
  endfunction

  task automatic ref_store(input logic byt, input logic [15:0] a, input logic [15:0] w);
    if (byt) begin
      ref_bytes[a[7:0]] = w[7:0];
    end else if (!a[0]) begin
      ref_bytes[a[7:0]]          = w[7:0];
      ref_bytes[a[7:0] + 8'd1]   = w[15:8];
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // A write lane must never be active without the memory enable.
  always @(negedge clk) begin
    if (!reset && (mem_we_low || mem_we_hi)) checkint("we_without_en", int'(mem_en), 1);
  end

  // Run one request and check response, latency, enable span and lanes.
  task automatic do_txn(input string name, input logic we, input logic byt,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_data, input logic exp_err, input int exp_lat,
                        input int exp_lo, input int exp_hi, input logic [15:0] exp_wd);
    int n;
    int lat;
    int en_cyc;
    int lo_cyc;
    int hi_cyc;
    logic [15:0] wd_seen;
    bit got;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checkint({name, " ready_wait"}, 0, 1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = byt;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    // Scramble request inputs: they must be ignored once accepted.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_byte  = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    lat = 0; en_cyc = 0; lo_cyc = 0; hi_cyc = 0; wd_seen = '0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_en) en_cyc++;
      if (mem_we_low) lo_cyc++;
      if (mem_we_hi) hi_cyc++;
      if (mem_we_low || mem_we_hi) wd_seen = mem_wdata;
      if (resp_valid) got = 1'b1;
    end
    checkint({name, " latency"}, lat, exp_lat);
    check16({name, " resp_data"}, resp_data, exp_data);
    checkint({name, " resp_err"}, int'(resp_err), int'(exp_err));
    checkint({name, " en_cycles"}, en_cyc, exp_lat - 1);
    checkint({name, " we_low_cycles"}, lo_cyc, exp_lo);
    checkint({name, " we_hi_cycles"}, hi_cyc, exp_hi);
    if (we && !exp_err) check16({name, " mem_wdata"}, wd_seen, exp_wd);
    @(negedge clk);
    checkint({name, " resp_pulse_end"}, int'(resp_valid), 0);
    checkint({name, " back_idle"}, int'(req_ready), 1);
  endtask

  typedef struct {
    logic        we;
    logic        byt;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_lo;
    int          exp_hi;
    logic [15:0] exp_wd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0;

    //            we    byt   addr      wdata     data      err   lat lo hi wd
    vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 3, 1, 1, 16'hBEEF};
    vecs[1]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 3, 0, 0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0020, 16'h3C7A, 16'h0000, 1'b0, 3, 1, 1, 16'h3C7A};
    vecs[3]  = '{1'b1, 1'b1, 16'h0021, 16'h0080, 16'h0000, 1'b0, 3, 0, 1, 16'h8080};
    vecs[4]  = '{1'b0, 1'b1, 16'h0021, 16'h0000, 16'hFF80, 1'b0, 3, 0, 0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 16'h0020, 16'h0000, 16'h007A, 1'b0, 3, 0, 0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1, 0, 0, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 16'h0005, 16'h1111, 16'h0000, 1'b1, 1, 0, 0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h807A, 1'b0, 3, 0, 0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 16'h0010, 16'hA5C3, 16'h0000, 1'b0, 3, 1, 0, 16'hC3C3};
    vecs[10] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEC3, 1'b0, 3, 0, 0, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'hFFBE, 1'b0, 3, 0, 0, 16'h0000};

    // Reset state.
    repeat (3) @(negedge clk);
    checkint("rst req_ready", int'(req_ready), 1);
    checkint("rst resp_valid", int'(resp_valid), 0);
    check16("rst resp_data", resp_data, 16'h0000);
    checkint("rst resp_err", int'(resp_err), 0);
    checkint("rst mem_en", int'(mem_en), 0);
    checkint("rst mem_we", int'(mem_we_low | mem_we_hi), 0);
    check16("rst mem_addr", mem_addr, 16'h0000);
    check16("rst mem_wdata", mem_wdata, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    // Directed vector table.
    mem_delay = 0;
    for (int i = 0; i < 12; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].byt, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_lo,
             vecs[i].exp_hi, vecs[i].exp_wd);
      if (vecs[i].we && !vecs[i].exp_err) ref_store(vecs[i].byt, vecs[i].addr, vecs[i].wdata);
    end

    // Timeout: memory never answers; ISSUE + 16 WAIT cycles then error.
    mem_stall = 1'b1;
    do_txn("timeout", 1'b0, 1'b0, 16'h0010, 16'h0, 16'h0000, 1'b1, 18, 0, 0, 16'h0);

    // Reset while waiting on memory aborts without a response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 16'h0020;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkint("abort pre mem_en", int'(mem_en), 1);
    reset = 1'b1;
    @(negedge clk);
    checkint("abort mem_en", int'(mem_en), 0);
    checkint("abort resp_valid", int'(resp_valid), 0);
    checkint("abort req_ready", int'(req_ready), 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkint("abort no_resp", int'(resp_valid), 0);
    end
    mem_stall = 1'b0;
    do_txn("after_abort", 1'b0, 1'b0, 16'h0020, 16'h0, ref_load(1'b0, 16'h0020), 1'b0, 3,
           0, 0, 16'h0);

    // Continuous req_valid with changing loads: only ready-cycle samples issue.
    begin
      logic [15:0] exp_q [$];
      logic        err_q [$];
      logic [15:0] iss_q [$];
      int accepts;
      int resps;
      logic prev_en;
      logic [15:0] e;
      accepts = 0; resps = 0; prev_en = 1'b0;
      mem_delay = 0;
      req_we = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 60; c++) begin
        if (c > 0) @(negedge clk);
        if (resp_valid) begin
          resps++;
          if (exp_q.size() == 0) begin
            checkint("stream unexpected_resp", resps, accepts);
          end else begin
            e = exp_q.pop_front();
            check16("stream resp_data", resp_data, e);
            checkint("stream resp_err", int'(resp_err), int'(err_q.pop_front()));
          end
        end
        if (mem_en && !prev_en) begin
          if (iss_q.size() == 0) begin
            checkint("stream unexpected_issue", 1, 0);
          end else begin
            check16("stream mem_addr", mem_addr, iss_q.pop_front());
          end
        end
        prev_en = mem_en;
        if (c < 40) begin
          req_valid = 1'b1;
          req_addr  = 16'($urandom);
          req_byte  = 1'($urandom);
          if (req_ready) begin
            accepts++;
            if (!req_byte && req_addr[0]) begin
              exp_q.push_back(16'h0000);
              err_q.push_back(1'b1);
            end else begin
              exp_q.push_back(ref_load(req_byte, req_addr));
              err_q.push_back(1'b0);
              iss_q.push_back(req_addr);
            end
          end
        end else begin
          req_valid = 1'b0;
        end
      end
      checkint("stream resp_count", resps, accepts);
      checkint("stream min_accepts", int'(accepts >= 8), 1);
      checkint("stream issue_left", iss_q.size(), 0);
    end

    // Randomized mix against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic we;
      logic byt;
      logic unal;
      logic [15:0] a;
      logic [15:0] w;
      we   = 1'($urandom);
      byt  = 1'($urandom);
      a    = 16'($urandom);
      w    = 16'($urandom);
      unal = !byt && a[0];
      mem_delay = $urandom_range(0, 3);
      do_txn($sformatf("rnd%0d", i), we, byt, a, w,
             (we || unal) ? 16'h0000 : ref_load(byt, a), unal,
             unal ? 1 : 3 + mem_delay,
             (we && !unal && (!byt || !a[0])) ? 1 : 0,
             (we && !unal && (!byt || a[0])) ? 1 : 0,
             byt ? {w[7:0], w[7:0]} : w);
      if (we && !unal) ref_store(byt, a, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
